// File: rtl/mem_access_unit.sv
// Load/store access unit: byte-enabled data memory, fixed-latency load FSM and LSQ forward path.
// Optional forward path is compiled in with `define MAU_FWD_EN.
module mem_access_unit #(
  parameter int MEM_WORDS = 1024,
  parameter int LOAD_LAT  = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  input  logic        fwd_valid,
  input  logic [31:0] fwd_data,
  input  logic [31:0] fwd_pc,
  output logic        mem_valid,
  output logic [31:0] mem_rdata,
  output logic [31:0] mem_pc,
  output logic        from_lsq,
  output logic [31:0] lsq_data,
  output logic [31:0] lsq_pc,
  output logic        store_done,
  output logic        misalign
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e             state_q;
  logic [3:0]         cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic [1:0]         lane_q;
  logic [1:0]         size_q;
  logic               unsigned_q;
  logic [31:0]        pc_q;
  logic               mem_valid_q, store_done_q, misalign_q;
  logic [31:0]        mem_rdata_q, mem_pc_q;

  logic [31:0]        mem [MEM_WORDS];

  logic [IDX_W-1:0]   req_idx;
  logic               req_misaligned;
  logic [1:0]         req_lane;
  logic [3:0]         req_be;
  logic [31:0]        req_wlanes;
  logic               accept;
  logic               resp_hold;
  logic [31:0]        rd_word, rd_shift, load_data;

  assign req_ready = (state_q == S_IDLE);
  assign accept    = req_valid && req_ready;
  assign req_idx   = req_addr[IDX_W+1:2];

  // Misaligned accesses are aligned down by forcing the low lane bits to zero.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    req_misaligned = 1'b0;
    req_lane       = 2'b00;
    req_be         = 4'b1111;
    req_wlanes     = req_wdata;
    case (req_size)
      2'b00: begin
        req_lane   = req_addr[1:0];
        req_be     = 4'b0001 << req_addr[1:0];
        req_wlanes = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_misaligned = req_addr[0];
        req_lane       = {req_addr[1], 1'b0};
        req_be         = req_addr[1] ? 4'b1100 : 4'b0011;
        req_wlanes     = {2{req_wdata[15:0]}};
      end
      default: req_misaligned = (req_addr[1:0] != 2'b00);
    endcase
  end

  always_comb begin
    rd_word   = mem[idx_q];
    rd_shift  = rd_word >> {lane_q, 3'b000};
    load_data = rd_word;
    case (size_q)
      2'b00:   load_data = {{24{~unsigned_q & rd_shift[7]}},  rd_shift[7:0]};
      2'b01:   load_data = {{16{~unsigned_q & rd_shift[15]}}, rd_shift[15:0]};
      default: load_data = rd_word;
    endcase
  end

  // NOTE: the memory array sits outside the reset domain; contents survive rstn.
  always_ff @(posedge clk) begin
    if (accept && req_is_store) begin
      for (int b = 0; b < 4; b++) begin
        if (req_be[b]) mem[req_idx][b*8 +: 8] <= req_wlanes[b*8 +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      lane_q       <= '0;
      size_q       <= '0;
      unsigned_q   <= 1'b0;
      pc_q         <= '0;
      mem_valid_q  <= 1'b0;
      mem_rdata_q  <= '0;
      mem_pc_q     <= '0;
      store_done_q <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      mem_valid_q  <= 1'b0;
      store_done_q <= 1'b0;
      misalign_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            misalign_q <= req_misaligned;
            if (req_is_store) begin
              store_done_q <= 1'b1;
            end else begin
              idx_q      <= req_idx;
              lane_q     <= req_lane;
              size_q     <= req_size;
              unsigned_q <= req_unsigned;
              pc_q       <= req_pc;
              if (LOAD_LAT == 1) begin
                cnt_q   <= '0;
                state_q <= S_RESP;
              end else begin
                cnt_q   <= 4'(LOAD_LAT - 1);
                state_q <= S_WAIT;
              end
            end
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= S_RESP;
        end
        S_RESP: begin
          if (!resp_hold) begin
            mem_valid_q <= 1'b1;
            mem_rdata_q <= load_data;
            mem_pc_q    <= pc_q;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_valid  = mem_valid_q;
  assign mem_rdata  = mem_rdata_q;
  assign mem_pc     = mem_pc_q;
  assign store_done = store_done_q;
  assign misalign   = misalign_q;

`ifdef MAU_FWD_EN
  logic        from_lsq_q;
  logic [31:0] lsq_data_q, lsq_pc_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      from_lsq_q <= 1'b0;
      lsq_data_q <= '0;
      lsq_pc_q   <= '0;
    end else begin
      from_lsq_q <= fwd_valid;
      if (fwd_valid) begin
        lsq_data_q <= fwd_data;
        lsq_pc_q   <= fwd_pc;
      end
    end
  end

  // Hold RESP while a forward strobe is showing or about to show, so the two strobes never overlap.
  assign resp_hold = from_lsq_q | fwd_valid;
  assign from_lsq  = from_lsq_q;
  assign lsq_data  = lsq_data_q;
  assign lsq_pc    = lsq_pc_q;

  logic unused_bits;
  assign unused_bits = ^req_addr[31:IDX_W+2];
`else
  assign resp_hold = 1'b0;
  assign from_lsq  = 1'b0;
  assign lsq_data  = '0;
  assign lsq_pc    = '0;

  logic unused_bits;
  assign unused_bits = ^{req_addr[31:IDX_W+2], fwd_valid, fwd_data, fwd_pc};
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit; covers the forward path when MAU_FWD_EN is defined.
module tb_mem_access_unit;

  localparam int LOAD_LAT = 2;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_ready, req_is_store, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, req_pc;
  logic        fwd_valid;
  logic [31:0] fwd_data, fwd_pc;
  logic        mem_valid, from_lsq, store_done, misalign;
  logic [31:0] mem_rdata, mem_pc, lsq_data, lsq_pc;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.MEM_WORDS(1024), .LOAD_LAT(LOAD_LAT)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_pc(req_pc),
    .fwd_valid(fwd_valid), .fwd_data(fwd_data), .fwd_pc(fwd_pc),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata), .mem_pc(mem_pc),
    .from_lsq(from_lsq), .lsq_data(lsq_data), .lsq_pc(lsq_pc),
    .store_done(store_done), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // The two response strobes must never coincide.
  always @(negedge clk) begin
    if (rstn === 1'b1) check("no_collision", {31'b0, mem_valid & from_lsq}, 32'h0);
  end

  // Presents one request for exactly one accepting edge; returns 1 time unit after that edge.
  task automatic issue(input logic st, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] pc);
    @(posedge clk); #1;
    req_is_store = st; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd; req_pc = pc; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic do_store(input string tag, input logic [1:0] sz, input logic [31:0] addr,
                          input logic [31:0] wd, input logic exp_mis);
    issue(1'b1, sz, 1'b0, addr, wd, 32'h0);
    @(negedge clk);
    check({tag, "_done"}, {31'b0, store_done}, 32'h1);
    check({tag, "_mis"}, {31'b0, misalign}, {31'b0, exp_mis});
    check({tag, "_nomv"}, {31'b0, mem_valid}, 32'h0);
    @(negedge clk);
    check({tag, "_done_off"}, {31'b0, store_done}, 32'h0);
  endtask

  task automatic do_load(input string tag, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] pc,
                         input logic [31:0] exp_data, input logic exp_mis);
    int n;
    logic mis, rdy0;
    n = 0; mis = 1'b0; rdy0 = 1'b1;
    issue(1'b0, sz, uns, addr, 32'h0, pc);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) begin mis = misalign; rdy0 = req_ready; end
      if (mem_valid) break;
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(LOAD_LAT));
    check({tag, "_data"}, mem_rdata, exp_data);
    check({tag, "_pc"}, mem_pc, pc);
    check({tag, "_mis"}, {31'b0, mis}, {31'b0, exp_mis});
    check({tag, "_busy"}, {31'b0, rdy0}, 32'h0);
  endtask

  initial begin
    rstn = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; req_pc = '0;
    fwd_valid = 1'b0; fwd_data = '0; fwd_pc = '0;

    repeat (2) @(negedge clk);
    check("rst_mem_valid", {31'b0, mem_valid}, 32'h0);
    check("rst_rdata", mem_rdata, 32'h0);
    check("rst_from_lsq", {31'b0, from_lsq}, 32'h0);
    rstn = 1'b1;
    @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'h1);

    // Store then load word; response strobe then data held afterwards.
    do_store("st_w", 2'b10, 32'h10, 32'hDEADBEEF, 1'b0);
    do_load("ld_w", 2'b10, 1'b0, 32'h10, 32'h200, 32'hDEADBEEF, 1'b0);
    @(negedge clk);
    check("ld_w_strobe_off", {31'b0, mem_valid}, 32'h0);
    check("ld_w_hold", mem_rdata, 32'hDEADBEEF);
    check("ld_w_ready", {31'b0, req_ready}, 32'h1);

    do_load("ld_b_s", 2'b00, 1'b0, 32'h13, 32'h204, 32'hFFFFFFDE, 1'b0);
    do_load("ld_b_u", 2'b00, 1'b1, 32'h13, 32'h208, 32'h000000DE, 1'b0);
    do_load("ld_h_mis", 2'b01, 1'b0, 32'h11, 32'h20C, 32'hFFFFBEEF, 1'b1);
    do_load("ld_w_mis", 2'b10, 1'b0, 32'h12, 32'h210, 32'hDEADBEEF, 1'b1);
    do_load("ld_sz3", 2'b11, 1'b0, 32'h10, 32'h214, 32'hDEADBEEF, 1'b0);
    do_load("ld_wrap", 2'b10, 1'b0, 32'h1010, 32'h218, 32'hDEADBEEF, 1'b0);

    // Byte-enable stores into a cleared word.
    do_store("st_w0", 2'b10, 32'h20, 32'h00000000, 1'b0);
    do_store("st_h_hi", 2'b01, 32'h22, 32'hAAAA1234, 1'b0);
    do_load("ld_after_h", 2'b10, 1'b0, 32'h20, 32'h220, 32'h12340000, 1'b0);
    do_store("st_b0", 2'b00, 32'h20, 32'h00000080, 1'b0);
    do_load("ld_b0_s", 2'b00, 1'b0, 32'h20, 32'h224, 32'hFFFFFF80, 1'b0);
    do_load("ld_h_hi_s", 2'b01, 1'b0, 32'h22, 32'h228, 32'h00001234, 1'b0);
    do_store("st_h_mis", 2'b01, 32'h23, 32'h0000CAFE, 1'b1);
    do_load("ld_after_mis", 2'b10, 1'b1, 32'h20, 32'h22C, 32'hCAFE0080, 1'b0);

`ifdef MAU_FWD_EN
    // Forward hit during WAIT: from_lsq first, load response pushed back one cycle.
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h300);
    fwd_valid = 1'b1; fwd_data = 32'h12345678; fwd_pc = 32'h00000ABC;
    @(negedge clk);
    check("fwd_wait_mv", {31'b0, mem_valid}, 32'h0);
    @(posedge clk); #1;
    fwd_valid = 1'b0;
    @(negedge clk);
    check("fwd_strobe", {31'b0, from_lsq}, 32'h1);
    check("fwd_data", lsq_data, 32'h12345678);
    check("fwd_pc", lsq_pc, 32'h00000ABC);
    check("fwd_mv_held0", {31'b0, mem_valid}, 32'h0);
    @(negedge clk);
    check("fwd_strobe_off", {31'b0, from_lsq}, 32'h0);
    check("fwd_mv_held1", {31'b0, mem_valid}, 32'h0);
    @(negedge clk);
    check("fwd_ld_mv", {31'b0, mem_valid}, 32'h1);
    check("fwd_ld_data", mem_rdata, 32'hDEADBEEF);
    check("fwd_ld_pc", mem_pc, 32'h300);
    @(negedge clk);
    check("fwd_hold", lsq_data, 32'h12345678);
`else
    // Forward inputs are ignored entirely in this build.
    fwd_valid = 1'b1; fwd_data = 32'h12345678; fwd_pc = 32'h00000ABC;
    do_load("nofwd_ld", 2'b10, 1'b0, 32'h10, 32'h300, 32'hDEADBEEF, 1'b0);
    check("nofwd_strobe", {31'b0, from_lsq}, 32'h0);
    check("nofwd_data", lsq_data, 32'h0);
    check("nofwd_pc", lsq_pc, 32'h0);
    fwd_valid = 1'b0;
`endif

    // Reset while a load is waiting: the load is dropped and every output clears.
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h400);
    @(negedge clk);
    check("inflight_busy", {31'b0, req_ready}, 32'h0);
    rstn = 1'b0;
    #1;
    check("r2_mem_valid", {31'b0, mem_valid}, 32'h0);
    check("r2_rdata", mem_rdata, 32'h0);
    check("r2_mem_pc", mem_pc, 32'h0);
    check("r2_store_done", {31'b0, store_done}, 32'h0);
    check("r2_misalign", {31'b0, misalign}, 32'h0);
    check("r2_from_lsq", {31'b0, from_lsq}, 32'h0);
    check("r2_lsq_data", lsq_data, 32'h0);
    check("r2_lsq_pc", lsq_pc, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("r2_dropped", {31'b0, mem_valid}, 32'h0);
    end
    check("r2_ready", {31'b0, req_ready}, 32'h1);
    do_load("post_rst", 2'b10, 1'b0, 32'h10, 32'h404, 32'hDEADBEEF, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, data memory depth in 32-bit words; word index is addr[log2(MEM_WORDS)+1:2].
REQ-002 SHALL have parameter LOAD_LAT, default 2, cycles from load acceptance to response (legal range 1..15).
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; rstn  in  1  asynchronous active-low reset.
REQ-004 req_valid  in  1  LSU request present.
REQ-005 req_ready  out  1  request accepted when req_valid && req_ready.
REQ-006 req_is_store  in  1  1 = store, 0 = load.
REQ-007 req_size  in  2  00 byte, 01 half, 10 word; 11 treated as word.
REQ-008 req_unsigned  in  1  zero-extend (1) or sign-extend (0) byte/half loads.
REQ-009 req_addr, req_wdata, req_pc  in  32 each  byte address, store data, instruction PC.
REQ-010 fwd_valid, fwd_data[31:0], fwd_pc[31:0]  in  LSQ store-to-load forward hit.
REQ-011 mem_valid  out  1  one-cycle load response strobe.
REQ-012 mem_rdata, mem_pc  out  32 each  load result and its PC, valid only with mem_valid.
REQ-013 from_lsq  out  1  one-cycle forward response strobe; lsq_data, lsq_pc  out  32 each.
REQ-014 store_done  out  1  one-cycle pulse, the cycle after a store is accepted.
REQ-015 misalign  out  1  one-cycle pulse, the cycle after a misaligned request is accepted.

Function
REQ-016 SHALL implement FSM IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-017 Store accepted in IDLE: SHALL write memory at that edge with byte enables from size/addr[1:0]; FSM stays IDLE; store_done = 1 next cycle; never asserts mem_valid.
REQ-018 Load accepted in IDLE: SHALL latch addr, size, unsigned and pc; go to WAIT with counter = LOAD_LAT-1; if LOAD_LAT = 1, go directly to RESP.
REQ-019 WAIT: SHALL decrement the counter each cycle and enter RESP the cycle it reaches 0.
REQ-020 RESP: SHALL assert mem_valid with extended data and latched pc, then return to IDLE, unless from_lsq is asserted that cycle.
REQ-021 mem_valid and from_lsq SHALL never be high in the same cycle; on a collision, RESP holds and mem_valid is asserted in the first cycle from_lsq is low.
REQ-022 Forward path: fwd_valid SHALL be registered to from_lsq, with lsq_data/lsq_pc, one cycle later, in any FSM state, without stalling requests.
REQ-023 Misaligned (half with addr[0] = 1, word with addr[1:0] != 0): SHALL align the address down, complete normally and pulse misalign.
REQ-024 Byte/half lane selection SHALL use addr[1:0] of the aligned address; extension SHALL follow req_unsigned.
REQ-025 Address bits above the memory index SHALL be ignored (wrap-around).
REQ-026 mem_rdata/mem_pc and lsq_data/lsq_pc SHALL hold their last values when their strobes are low.

Reset
REQ-027 On rstn low, SHALL go to IDLE and clear the counter, mem_valid, from_lsq, store_done, misalign, mem_rdata, mem_pc, lsq_data and lsq_pc to 0; req_ready = 1 after release.
REQ-028 A load in flight during reset SHALL be dropped with no response; memory contents are not reset.

Configuration
REQ-029 With MAU_FWD_EN defined, the forward path (REQ-010, REQ-013, REQ-021, REQ-022) SHALL be present.
REQ-030 Without MAU_FWD_EN, from_lsq, lsq_data and lsq_pc SHALL be constant 0, fwd_* SHALL be ignored and RESP SHALL never hold.

Verification
REQ-031 Store word 0xDEADBEEF @0x10, then load word @0x10, LOAD_LAT = 2 -> store_done next cycle; mem_valid exactly 2 cycles after the load is accepted, rdata 0xDEADBEEF, pc matches.
REQ-032 Load byte @0x13, signed, then unsigned -> 0xFFFFFFDE, then 0x000000DE.
REQ-033 fwd_valid with fwd_data 0x12345678 in the cycle before RESP -> from_lsq = 1 with 0x12345678; mem_valid delayed 1 cycle; never both high.
REQ-034 Load half @0x11 -> misalign pulse; data from 0x10 (0xBEEF sign-extended to 0xFFFFBEEF).
REQ-035 rstn low while in WAIT -> no mem_valid ever; all outputs 0; req_ready = 1 after release.
REQ-036 Build without MAU_FWD_EN, drive fwd_valid = 1 continuously -> from_lsq stays 0; load response timing unchanged.
